// File: rtl/mic_pkg.sv
// Shared constants and FSM encoding for the microphone peak meter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mic_pkg;

   // Raw ADC sample width and derived widths.
   localparam int MIC_SAMPLE_W = 12;
   localparam int AMP_W        = 11;
   localparam int LEVEL_SHIFT  = 7;
   localparam int VOLUME_W     = 5;

   // Level is the top bits of the amplitude: 11 - 7 = 4 bits, 0..15.
   localparam int LEVEL_W      = AMP_W - LEVEL_SHIFT;

   // Sample counter width; covers WINDOW up to 65535.
   localparam int CNT_W        = 16;

   typedef enum logic {
      ST_ACCUM   = 1'b0,   // collecting samples of the current window
      ST_PUBLISH = 1'b1    // one cycle: loading volume from the finished window
   } mic_state_e;

   // Larger of two amplitudes.
   function automatic logic [AMP_W-1:0] amp_max(input logic [AMP_W-1:0] a,
                                                input logic [AMP_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mic_level_quant.sv
// Amplitude extraction and level quantisation for one microphone sample.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   mic_in     - unsigned 12-bit ADC sample
//   peak       - running peak of the window so far
//   final_amp  - max(peak, |mic_in - MID|), amplitude saturated to 2047
//   level      - final_amp >> LEVEL_SHIFT, 0..15
module mic_level_quant
   import mic_pkg::*;
#(
   parameter int MID = 2048
) (
   input  logic [MIC_SAMPLE_W-1:0] mic_in,
   input  logic [AMP_W-1:0]        peak,
   output logic [AMP_W-1:0]        final_amp,
   output logic [LEVEL_W-1:0]      level
);

   localparam logic [MIC_SAMPLE_W-1:0] MID_C = MIC_SAMPLE_W'(MID);

   logic [MIC_SAMPLE_W-1:0] mag;
   logic [AMP_W-1:0]        amp;

   // Magnitude of the offset from the zero-signal code; computed from the
   // larger operand down so no signed arithmetic is needed.
   always_comb begin
      if (mic_in >= MID_C) begin
         mag = mic_in - MID_C;
      end else begin
         mag = MID_C - mic_in;
      end
   end

   // The full-scale negative swing (e.g. 0 vs 2048) is 2048, one past the
   // 11-bit range, so anything with the top bit set clips to 2047.
   assign amp       = mag[MIC_SAMPLE_W-1] ? {AMP_W{1'b1}} : mag[AMP_W-1:0];
   assign final_amp = amp_max(peak, amp);
   assign level     = final_amp[AMP_W-1:LEVEL_SHIFT];

endmodule

// File: rtl/mic_peak_meter.sv
// Windowed peak meter: tracks the largest |sample - MID| over WINDOW accepted
// samples and publishes a 0..15 volume level once per window.
// Latency: volume/volume_valid update 2 clocks after the last sample's strobe.
// Backpressure: none; every strobed sample is accepted, including during publish.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   en            - meter enable; low clears all measurement state
//   sample_valid  - single-cycle strobe qualifying mic_in
//   mic_in        - unsigned 12-bit ADC sample
//   volume        - current level 0..15 (bit 4 always 0), held between publishes
//   volume_valid  - one-cycle pulse when volume is updated
//   peak          - running peak amplitude of the current window (debug)
//
// Build option: define MIC_PEAK_HOLD_EN for peak-hold display behaviour, where
// a quieter window only lets the volume fall by one step per publish.
module mic_peak_meter
   import mic_pkg::*;
#(
   parameter int WINDOW = 4000,
   parameter int MID    = 2048
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    sample_valid,
   input  logic [MIC_SAMPLE_W-1:0] mic_in,
   output logic [VOLUME_W-1:0]     volume,
   output logic                    volume_valid,
   output logic [AMP_W-1:0]        peak
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

   mic_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [AMP_W-1:0]     peak_q, peak_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [VOLUME_W-1:0]  volume_q, volume_d;
   logic                 volume_valid_q, volume_valid_d;

   logic [AMP_W-1:0]     final_amp;
   logic [LEVEL_W-1:0]   level;
   logic [VOLUME_W-1:0]  level_ext;
   logic [VOLUME_W-1:0]  new_volume;
   logic                 accept;
   logic                 last_sample;

   mic_level_quant #(
      .MID       (MID)
   ) u_quant (
      .mic_in    (mic_in),
      .peak      (peak_q),
      .final_amp (final_amp),
      .level     (level)
   );

   assign accept      = en & sample_valid;
   assign last_sample = accept && (cnt_q == LAST_CNT);

   // Level of the window just closed, widened to the volume port.
   assign level_ext = {{(VOLUME_W - LEVEL_W){1'b0}}, level_q};

`ifdef MIC_PEAK_HOLD_EN
   // Rise immediately, fall by at most one step per window.
   assign new_volume = (level_ext >= volume_q) ? level_ext : (volume_q - 1'b1);
`else
   assign new_volume = level_ext;
`endif

   // Next-state and output logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      peak_d         = peak_q;
      level_d        = level_q;
      volume_d       = volume_q;
      volume_valid_d = 1'b0;

      if (!en) begin
         // Disable wins over everything, including a last sample in the
         // same cycle: the window is dropped and nothing is published.
         state_d  = ST_ACCUM;
         cnt_d    = '0;
         peak_d   = '0;
         level_d  = '0;
         volume_d = '0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (last_sample) begin
                  state_d = ST_PUBLISH;
               end
            end
            ST_PUBLISH: begin
               state_d        = ST_ACCUM;
               volume_d       = new_volume;
               volume_valid_d = 1'b1;
            end
            default: begin
               state_d = ST_ACCUM;
            end
         endcase

         // Sample accumulation runs independently of the FSM so that a
         // sample arriving during PUBLISH opens the next window.
         if (accept) begin
            if (last_sample) begin
               // The closing sample is folded into the level here; peak
               // restarts from zero for the next window at this same edge.
               cnt_d   = '0;
               peak_d  = '0;
               level_d = level;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               peak_d = final_amp;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_ACCUM;
         cnt_q          <= '0;
         peak_q         <= '0;
         level_q        <= '0;
         volume_q       <= '0;
         volume_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         peak_q         <= peak_d;
         level_q        <= level_d;
         volume_q       <= volume_d;
         volume_valid_q <= volume_valid_d;
      end
   end

   assign volume       = volume_q;
   assign volume_valid = volume_valid_q;
   assign peak         = peak_q;

endmodule

// File: tb/tb_mic_peak_meter.sv
// Self-checking bench for mic_peak_meter with WINDOW=4, MID=2048.
// Stimulus pushes expected (volume, cycle) pairs; a monitor pops on each pulse.
// Expected values follow the MIC_PEAK_HOLD_EN setting of the build.
module tb_mic_peak_meter;

   localparam int WINDOW = 4;
   localparam int MID    = 2048;

`ifdef MIC_PEAK_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] mic_in = 12'd0;
   logic [4:0]  volume;
   logic        volume_valid;
   logic [10:0] peak;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_vol_q[$];
   int exp_cyc_q[$];
   int mon_ev;
   int mon_ec;

   mic_peak_meter #(
      .WINDOW       (WINDOW),
      .MID          (MID)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .sample_valid (sample_valid),
      .mic_in       (mic_in),
      .volume       (volume),
      .volume_valid (volume_valid),
      .peak         (peak)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: each volume_valid cycle must match the next queued expectation,
   // both in value and in the cycle it appears.
   always @(negedge clk) begin
      if (volume_valid) begin
         if (exp_vol_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse actual=volume_valid volume=%0d required=no pulse (cyc=%0d)",
                     volume, cyc);
         end else begin
            mon_ev = exp_vol_q.pop_front();
            mon_ec = exp_cyc_q.pop_front();
            check("pulse_volume", int'(volume), mon_ev);
            check("pulse_cycle", cyc, mon_ec);
         end
      end
   end

   // Called at posedge+1; leaves the bench at the next posedge+1.
   task automatic send(input logic [11:0] x, input bit do_push, input int ev);
      sample_valid = 1'b1;
      mic_in       = x;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      if (do_push) begin
         exp_vol_q.push_back(ev);
         exp_cyc_q.push_back(cyc + 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [11:0] b2b_smp [12];
   int          b2b_exp [3];

   initial begin
      // Reset state.
      #12;
      check("rst_volume", int'(volume), 0);
      check("rst_volume_valid", int'(volume_valid), 0);
      check("rst_peak", int'(peak), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b1;
      idle(1);

      // Basic window: peak 252 -> level 1.
      send(12'd2048, 0, 0);
      send(12'd2300, 0, 0);
      send(12'd2100, 0, 0);
      check("t1_peak_running", int'(peak), 252);
      send(12'd2048, 1, 1);
      check("t1_peak_cleared", int'(peak), 0);
      idle(4);
      check("t1_volume_held", int'(volume), 1);
      check("t1_volume_bit4", int'(volume[4]), 0);

      // Saturating amplitude: sample 0 -> 2047 -> level 15.
      send(12'd2048, 0, 0);
      send(12'd2048, 0, 0);
      send(12'd2048, 0, 0);
      send(12'd0, 1, 15);
      check("t2_peak_cleared", int'(peak), 0);
      idle(3);
      check("t2_volume_held", int'(volume), 15);

      // Reset mid-window: partial window discarded, full window needed after.
      send(12'd3000, 0, 0);
      send(12'd3000, 0, 0);
      check("t4_peak_partial", int'(peak), 952);
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_rst_volume", int'(volume), 0);
      check("t4_rst_peak", int'(peak), 0);
      check("t4_rst_volume_valid", int'(volume_valid), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(12'd3000, 0, 0);
      send(12'd3000, 0, 0);
      send(12'd3000, 0, 0);
      send(12'd3000, 1, 7);
      idle(3);

      // Enable drops on the last sample: no publish, state cleared.
      send(12'd4095, 0, 0);
      send(12'd4095, 0, 0);
      send(12'd4095, 0, 0);
      check("t5_peak_running", int'(peak), 2047);
      en = 1'b0;
      send(12'd4095, 0, 0);
      check("t5_volume_cleared", int'(volume), 0);
      check("t5_peak_cleared", int'(peak), 0);
      check("t5_no_valid", int'(volume_valid), 0);
      idle(1);
      check("t5_volume_stays", int'(volume), 0);
      en = 1'b1;
      idle(1);
      // Counter restarted from 0: publish only on the 4th sample.
      send(12'd2048, 0, 0);
      send(12'd2048, 0, 0);
      send(12'd3000, 0, 0);
      send(12'd2048, 1, 7);
      idle(3);

      // Back-to-back samples: three windows, pulses 4 cycles apart.
      b2b_smp = '{12'd2048, 12'd2048, 12'd2048, 12'd3000,
                  12'd2048, 12'd2048, 12'd1000, 12'd2048,
                  12'd2048, 12'd2048, 12'd2048, 12'd2048};
      // Volume is 7 coming in; levels are 7, 8, 0.
      b2b_exp[0] = 7;
      b2b_exp[1] = 8;
      b2b_exp[2] = HOLD ? 7 : 0;
      for (int i = 0; i < 12; i++) begin
         send(b2b_smp[i], (i % 4) == 3, b2b_exp[i / 4]);
      end
      idle(3);

      // Loud window then silence: decay with peak hold, drop without.
      send(12'd2048, 0, 0);
      send(12'd2048, 0, 0);
      send(12'd2048, 0, 0);
      send(12'd0, 1, 15);
      for (int w = 0; w < 3; w++) begin
         send(12'd2048, 0, 0);
         send(12'd2048, 0, 0);
         send(12'd2048, 0, 0);
         send(12'd2048, 1, HOLD ? (14 - w) : 0);
      end
      idle(3);
      check("t6_final_volume", int'(volume), HOLD ? 12 : 0);

      // Every expected pulse must have been seen.
      idle(4);
      while (exp_vol_q.size() != 0) begin
         checks++;
         errors++;
         mon_ev = exp_vol_q.pop_front();
         mon_ec = exp_cyc_q.pop_front();
         $display("FAIL missing_pulse actual=none required=volume %0d at cyc %0d", mon_ev, mon_ec);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mic_peak_meter.md
MIC_PEAK_METER -- requirements
Module: mic_peak_meter

Interface
REQ-001 SHALL have parameter WINDOW, default 4000, meaning accepted samples per measurement window (legal 2..65535).
REQ-002 SHALL have parameter MID, default 2048, meaning the 12-bit ADC code for zero signal.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-005 SHALL have port en  input  1  meter enable; low clears the measurement.
REQ-006 SHALL have port sample_valid  input  1  single-cycle strobe qualifying mic_in.
REQ-007 SHALL have port mic_in  input  12  unsigned microphone ADC sample.
REQ-008 SHALL have port volume  output  5  current level, 0..15, bit 4 always 0, consumed by the bar display.
REQ-009 SHALL have port volume_valid  output  1  one-cycle pulse when volume is updated by a window.
REQ-010 SHALL have port peak  output  11  running peak amplitude of the current window (debug).

Function
REQ-011 SHALL compute amplitude = |mic_in - MID|, 11-bit, saturated at 2047 (mic_in=0 with MID=2048 gives 2047).
REQ-012 SHALL count accepted samples (sample_valid high and en high) in a counter running 0..WINDOW-1, wrapping to 0.
REQ-013 SHALL set peak <= max(peak, amplitude) on each accepted sample except the last of a window.
REQ-014 SHALL, on the accepted sample with counter = WINDOW-1, form final = max(peak, amplitude), include that sample, and clear peak to 0 at the same edge.
REQ-015 SHALL quantise level = final >> 7 (0..15) in the sub-module; no other scaling.
REQ-016 SHALL use a two-state FSM: ACCUM (collecting) -> PUBLISH on the last accepted sample; PUBLISH -> ACCUM unconditionally after one cycle.
REQ-017 SHALL, in PUBLISH, load volume with the new level and assert volume_valid for exactly that cycle: latency 1 clock after the final sample edge, 2 clocks from sample_valid high.
REQ-018 SHALL accept a sample arriving while in PUBLISH as the first sample of the next window (no sample lost, no stall).
REQ-019 SHALL, when en is low, hold counter=0, peak=0, FSM=ACCUM, volume=0, volume_valid=0 from the next edge; samples ignored.
REQ-020 SHALL, when en deasserts in the same cycle as a last sample, give en priority: no publish, volume=0.
REQ-021 SHALL hold volume constant between publishes.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force volume=0, volume_valid=0, peak=0, counter=0, FSM=ACCUM.
REQ-023 SHALL, if reset falls mid-window, discard the partial window; the first window after release is a full WINDOW samples.

Configuration
REQ-024 SHALL support macro MIC_PEAK_HOLD_EN.
REQ-025 SHALL, with MIC_PEAK_HOLD_EN defined, in PUBLISH load volume = level if level >= volume, else volume-1 (one-step decay per window).
REQ-026 SHALL, without MIC_PEAK_HOLD_EN, in PUBLISH load volume = level unconditionally.

Structure
REQ-027 SHALL place MIC_SAMPLE_W=12, AMP_W=11, LEVEL_SHIFT=7, VOLUME_W=5 and the FSM state enum in shared package mic_pkg.
REQ-028 SHALL implement amplitude-to-level quantisation (REQ-011, REQ-015) in combinational sub-module mic_level_quant, instantiated once.

Verification
REQ-029 SHALL cover: WINDOW=4, MID=2048, samples 2048,2300,2100,2048 -> peak 252, volume_valid one cycle after 4th sample, volume=1.
REQ-030 SHALL cover: WINDOW=4, last sample 0 (amplitude 2047) with prior 2048s -> volume=15, peak=0 after publish.
REQ-031 SHALL cover: back-to-back sample_valid every cycle for 12 cycles, WINDOW=4 -> exactly 3 volume_valid pulses, 4 cycles apart.
REQ-032 SHALL cover: rst_n pulsed low after 2 samples of a window -> volume=0 immediately; next pulse only after 4 further samples.
REQ-033 SHALL cover: en low on the 4th sample edge -> no volume_valid, volume=0, counter=0.
REQ-034 SHALL cover: MIC_PEAK_HOLD_EN, volume=15 then windows of silence -> volume 14,13,12 on successive pulses; without macro -> 0 on first pulse.
